// File: rtl/jtag_tap_controller_if.sv
// Signal bundle between the TAP controller and its test-access host / external DR chain.
// The slave modport is the TAP itself; master is the side that drives TMS/TDI.
interface jtag_tap_controller_if #(
  parameter int unsigned IR_WIDTH = 4
);
  logic                tms;
  logic                tdi;
  logic                ext_tdo;
  logic                tdo;
  logic                tdo_en;
  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir;
  logic                ext_sel;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;

  modport master (
    output tms, tdi, ext_tdo,
    input  tdo, tdo_en, state, ir, ext_sel, capture_dr, shift_dr, update_dr
  );

  modport slave (
    input  tms, tdi, ext_tdo,
    output tdo, tdo_en, state, ir, ext_sel, capture_dr, shift_dr, update_dr
  );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP: 16-state TMS FSM, instruction, bypass and IDCODE registers.
// Drives capture/shift/update strobes for the external DR chain and muxes TDO.
module jtag_tap_controller #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_EXTEST    = '0,
  parameter logic [IR_WIDTH-1:0] OP_BYPASS    = '1
) (
  input logic                  clk,
  input logic                  reset,
  jtag_tap_controller_if.slave bus
);

  typedef enum logic [3:0] {
    StTlr     = 4'd0,
    StRti     = 4'd1,
    StSelDr   = 4'd2,
    StCapDr   = 4'd3,
    StShiftDr = 4'd4,
    StExit1Dr = 4'd5,
    StPauseDr = 4'd6,
    StExit2Dr = 4'd7,
    StUpdDr   = 4'd8,
    StSelIr   = 4'd9,
    StCapIr   = 4'd10,
    StShiftIr = 4'd11,
    StExit1Ir = 4'd12,
    StPauseIr = 4'd13,
    StExit2Ir = 4'd14,
    StUpdIr   = 4'd15
  } tap_state_e;

  tap_state_e          state_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic                bypass_q;
  logic [31:0]         idcode_sr_q;

  logic sel_ext;
  logic sel_idcode;
  logic sel_bypass;
  logic tdo;

  assign sel_ext    = (ir_q == OP_EXTEST);
  assign sel_idcode = (ir_q == OP_IDCODE) && !sel_ext;
  // Any opcode that is neither IDCODE nor EXTEST falls back to bypass.
  assign sel_bypass = (ir_q == OP_BYPASS) || !(sel_ext || sel_idcode);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StTlr;
      ir_q        <= OP_IDCODE;
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      idcode_sr_q <= IDCODE_VALUE;
    end else begin
      unique case (state_q)
        StTlr:     state_q <= bus.tms ? StTlr     : StRti;
        StRti:     state_q <= bus.tms ? StSelDr   : StRti;
        StSelDr:   state_q <= bus.tms ? StSelIr   : StCapDr;
        StCapDr:   state_q <= bus.tms ? StExit1Dr : StShiftDr;
        StShiftDr: state_q <= bus.tms ? StExit1Dr : StShiftDr;
        StExit1Dr: state_q <= bus.tms ? StUpdDr   : StPauseDr;
        StPauseDr: state_q <= bus.tms ? StExit2Dr : StPauseDr;
        StExit2Dr: state_q <= bus.tms ? StUpdDr   : StShiftDr;
        StUpdDr:   state_q <= bus.tms ? StSelDr   : StRti;
        StSelIr:   state_q <= bus.tms ? StTlr     : StCapIr;
        StCapIr:   state_q <= bus.tms ? StExit1Ir : StShiftIr;
        StShiftIr: state_q <= bus.tms ? StExit1Ir : StShiftIr;
        StExit1Ir: state_q <= bus.tms ? StUpdIr   : StPauseIr;
        StPauseIr: state_q <= bus.tms ? StExit2Ir : StPauseIr;
        StExit2Ir: state_q <= bus.tms ? StUpdIr   : StShiftIr;
        StUpdIr:   state_q <= bus.tms ? StSelDr   : StRti;
        default:   state_q <= StTlr;
      endcase

      case (state_q)
        StTlr:     ir_q    <= OP_IDCODE;
        StCapIr:   ir_sr_q <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
        StShiftIr: ir_sr_q <= {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
        StUpdIr:   ir_q    <= ir_sr_q;
        StCapDr: begin
          if (sel_idcode)      idcode_sr_q <= IDCODE_VALUE;
          else if (sel_bypass) bypass_q    <= 1'b0;
        end
        StShiftDr: begin
          if (sel_idcode)      idcode_sr_q <= {bus.tdi, idcode_sr_q[31:1]};
          else if (sel_bypass) bypass_q    <= bus.tdi;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state_q == StShiftIr) begin
      tdo = ir_sr_q[0];
    end else if (state_q == StShiftDr) begin
      if (sel_idcode)   tdo = idcode_sr_q[0];
      else if (sel_ext) tdo = bus.ext_tdo;
      else              tdo = bypass_q;
    end
  end

  // Strobes decode only registered state, so they cannot glitch within a TCK cycle.
  assign bus.tdo        = tdo;
  assign bus.tdo_en     = (state_q == StShiftDr) || (state_q == StShiftIr);
  assign bus.state      = state_q;
  assign bus.ir         = ir_q;
  assign bus.ext_sel    = sel_ext;
  assign bus.capture_dr = sel_ext && (state_q == StCapDr);
  assign bus.shift_dr   = sel_ext && (state_q == StShiftDr);
  assign bus.update_dr  = sel_ext && (state_q == StUpdDr);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: FSM walk, IDCODE/BYPASS/EXTEST scans,
// pause retention and reset abort of an IR scan.
module tb_jtag_tap_controller;

  localparam int unsigned IrWidth     = 4;
  localparam logic [31:0] IdcodeValue = 32'h1000_0001;
  localparam int          WalkLen     = 47;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  int walk_tms [WalkLen] = '{0, 0, 1, 1, 1, 1, 0, 1, 0, 1,
                             0, 0, 1, 0, 1, 1, 1, 1, 0, 1,
                             0, 0, 1, 0, 1, 1, 0, 1, 0, 0,
                             0, 1, 0, 1, 1, 0, 1, 1, 0, 0,
                             1, 0, 1, 1, 1, 1, 1};
  int walk_st  [WalkLen] = '{1, 1, 2, 9, 0, 0, 1, 2, 3, 5,
                             6, 6, 7, 4, 5, 8, 2, 9, 10, 12,
                             13, 13, 14, 11, 12, 15, 1, 2, 3, 4,
                             4, 5, 6, 7, 8, 1, 2, 9, 10, 11,
                             12, 13, 14, 15, 2, 9, 0};

  jtag_tap_controller_if #(.IR_WIDTH(IrWidth)) bus ();

  jtag_tap_controller #(
    .IR_WIDTH    (IrWidth),
    .IDCODE_VALUE(IdcodeValue),
    .OP_IDCODE   (4'b0001),
    .OP_EXTEST   (4'b0000),
    .OP_BYPASS   (4'b1111)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From RTI: scan op into IR, return the captured bits shifted out, end in RTI.
  task automatic load_ir(input logic [IrWidth-1:0] op, output logic [IrWidth-1:0] out);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("shift_ir_state", 32'(bus.state), 32'd11);
    check("shift_ir_tdo_en", 32'(bus.tdo_en), 32'd1);
    for (int i = 0; i < IrWidth; i++) begin
      out[i] = bus.tdo;
      tick(i == IrWidth - 1, op[i]);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0]        id_bits;
    logic [IrWidth-1:0] ir_out;
    logic [3:0]         byp_obs;
    logic [3:0]         byp_tdi;
    logic [2:0]         ext_pat;
    int                 n_shift;

    bus.tms     = 1'b1;
    bus.tdi     = 1'b0;
    bus.ext_tdo = 1'b0;
    byp_tdi     = 4'b1101;  // sent LSB first: 1,0,1,1
    ext_pat     = 3'b101;

    tick(1'b1, 1'b0);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_ir", 32'(bus.ir), 32'h1);
    check("rst_tdo_en", 32'(bus.tdo_en), 32'd0);
    check("rst_tdo", 32'(bus.tdo), 32'd0);
    reset = 1'b0;
    repeat (3) tick(1'b1, 1'b0);
    check("tlr_state", 32'(bus.state), 32'd0);
    check("tlr_ir", 32'(bus.ir), 32'h1);
    check("tlr_ext_sel", 32'(bus.ext_sel), 32'd0);

    for (int i = 0; i < WalkLen; i++) begin
      tick(walk_tms[i][0], 1'b0);
      check($sformatf("walk_%0d", i), 32'(bus.state), 32'(walk_st[i]));
    end
    tick(1'b1, 1'b0);
    check("walk_end_state", 32'(bus.state), 32'd0);
    check("walk_end_ir", 32'(bus.ir), 32'h1);

    // IDCODE scan
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("id_cap_state", 32'(bus.state), 32'd3);
    check("id_cap_strobe", 32'(bus.capture_dr), 32'd0);
    tick(1'b0, 1'b0);
    check("id_tdo_en", 32'(bus.tdo_en), 32'd1);
    check("id_first_tdo", 32'(bus.tdo), 32'd1);
    check("id_shift_strobe", 32'(bus.shift_dr), 32'd0);
    for (int i = 0; i < 32; i++) begin
      id_bits[i] = bus.tdo;
      tick(i == 31, 1'b0);
    end
    check("id_bits", id_bits, IdcodeValue);
    check("id_exit1", 32'(bus.state), 32'd5);
    tick(1'b1, 1'b0);
    check("id_upd_strobe", 32'(bus.update_dr), 32'd0);
    tick(1'b0, 1'b0);

    load_ir(4'b1111, ir_out);
    check("byp_ir_out", 32'(ir_out), 32'h1);
    check("byp_ir", 32'(bus.ir), 32'hf);
    check("byp_rti", 32'(bus.state), 32'd1);

    // BYPASS scan with a pause in the middle
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      byp_obs[i] = bus.tdo;
      tick(i == 3, byp_tdi[i]);
    end
    check("byp_tdo_seq", 32'(byp_obs), 32'b1010);
    check("byp_exit1", 32'(bus.state), 32'd5);
    repeat (5) tick(1'b0, 1'b0);
    check("byp_pause", 32'(bus.state), 32'd6);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("byp_reshift", 32'(bus.state), 32'd4);
    check("byp_held_bit", 32'(bus.tdo), 32'd1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    load_ir(4'b0000, ir_out);
    check("ext_ir_out", 32'(ir_out), 32'h1);
    check("ext_ir", 32'(bus.ir), 32'h0);
    check("ext_sel", 32'(bus.ext_sel), 32'd1);

    // EXTEST scan: strobes and tdo passthrough
    tick(1'b1, 1'b0);
    check("ext_sel_dr_cap", 32'(bus.capture_dr), 32'd0);
    tick(1'b0, 1'b0);
    check("ext_cap_strobe", 32'(bus.capture_dr), 32'd1);
    check("ext_cap_noshift", 32'(bus.shift_dr), 32'd0);
    tick(1'b0, 1'b0);
    check("ext_cap_done", 32'(bus.capture_dr), 32'd0);
    n_shift = 0;
    for (int i = 0; i < 3; i++) begin
      bus.ext_tdo = ext_pat[i];
      #1;
      check($sformatf("ext_tdo_%0d", i), 32'(bus.tdo), 32'(ext_pat[i]));
      n_shift += int'(bus.shift_dr);
      tick(i == 2, 1'b0);
    end
    check("ext_shift_count", 32'(n_shift), 32'd3);
    check("ext_exit1_noshift", 32'(bus.shift_dr), 32'd0);
    tick(1'b1, 1'b0);
    check("ext_upd_strobe", 32'(bus.update_dr), 32'd1);
    tick(1'b0, 1'b0);
    check("ext_upd_done", 32'(bus.update_dr), 32'd0);

    // Reset in the middle of an IR scan
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    reset = 1'b1;
    tick(1'b0, 1'b1);
    reset = 1'b0;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_ir", 32'(bus.ir), 32'h1);
    check("abort_ext_sel", 32'(bus.ext_sel), 32'd0);
    check("abort_tdo_en", 32'(bus.tdo_en), 32'd0);
    tick(1'b0, 1'b0);
    check("abort_ir_kept", 32'(bus.ir), 32'h1);

    // Five TMS=1 edges from SHIFT_DR reach TLR
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("five_start", 32'(bus.state), 32'd4);
    repeat (5) tick(1'b1, 1'b0);
    check("five_ones_tlr", 32'(bus.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller: a 16-state TMS-driven FSM plus an instruction register, a bypass register and an IDCODE register. It is the control stage directly upstream of the team's sync-reset flip-flop data/boundary registers. It produces the capture/shift/update strobes and the external-register select that those flip-flop chains consume. It also muxes their serial output onto tdo.

Parameters:
IR_WIDTH, 4, instruction register width (min 2)
IDCODE_VALUE, 32'h1000_0001, device ID; bit 0 must be 1
OP_IDCODE, 4'b0001, IDCODE opcode; also the IR value after reset
OP_EXTEST, 4'b0000, opcode that selects the external data register
OP_BYPASS, 4'b1111, bypass opcode (all ones); any undefined opcode also acts as bypass

Ports:
clk  in  1  TCK; all state changes on rising edge
reset  in  1  synchronous, active-high
tms  in  1  test mode select, sampled on rising clk
tdi  in  1  test data in, sampled on rising clk
ext_tdo  in  1  serial output of external DR chain
tdo  out  1  serial data out
tdo_en  out  1  high while in SHIFT_DR or SHIFT_IR
state  out  4  current FSM state (encoding below)
ir  out  IR_WIDTH  active (updated) instruction
ext_sel  out  1  high when ir == OP_EXTEST
capture_dr  out  1  ext_sel & state==CAPTURE_DR
shift_dr  out  1  ext_sel & state==SHIFT_DR
update_dr  out  1  ext_sel & state==UPDATE_DR

Behaviour:
- Reset is synchronous and active-high on clk. At the reset edge: state=TEST_LOGIC_RESET, ir=OP_IDCODE, IR shift reg=0, bypass=0, IDCODE shift reg=IDCODE_VALUE. tdo_en=0 and tdo=0 follow combinationally from this.
- State encoding: TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SHIFT_DR=4, EXIT1_DR=5, PAUSE_DR=6, EXIT2_DR=7, UPD_DR=8, SEL_IR=9, CAP_IR=10, SHIFT_IR=11, EXIT1_IR=12, PAUSE_IR=13, EXIT2_IR=14, UPD_IR=15.
- Transitions are given as next state for tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SHIFT_DR / EXIT1_DR
  - SHIFT_DR: SHIFT_DR / EXIT1_DR
  - EXIT1_DR: PAUSE_DR / UPD_DR
  - PAUSE_DR: PAUSE_DR / EXIT2_DR
  - EXIT2_DR: SHIFT_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - The IR column (CAP_IR to UPD_IR) mirrors the DR column.
- Five consecutive tms=1 edges reach TLR from any state.
- Register actions on the rising edge while the current state is:
  - CAP_IR: IR shift reg <= {0..0,01}.
  - SHIFT_IR: IR shift reg <= {tdi, sr[IR_WIDTH-1:1]} (LSB out first).
  - UPD_IR: ir <= IR shift reg.
  - TLR: ir <= OP_IDCODE.
  - CAP_DR: selected internal DR loads: bypass <= 0; IDCODE sr <= IDCODE_VALUE.
  - SHIFT_DR: selected internal DR shifts right with tdi into the MSB. Bypass is 1 bit: bypass <= tdi.
  - Unselected registers hold.
- tdo is combinational. It is valid during the SHIFT state and changes after the edge:
  - SHIFT_IR: IR shift reg[0]
  - SHIFT_DR: IDCODE sr[0], bypass, or ext_tdo, per ir
  - otherwise: 0
- Strobes are combinational decodes of the registered state and are glitch-free relative to clk. update_dr is high for exactly one cycle per UPD_DR visit.
- ir changes only in UPD_IR or TLR. ext_sel is therefore stable throughout any DR scan.
- Pause states hold all shift registers unchanged for any number of cycles.
- Reset asserted mid-scan aborts the scan. Partially shifted IR content is discarded, and ir returns to OP_IDCODE.

Test Plan:
- reset=1 for 1 edge, then tms=1 x3 -> state=0, ir=4'b0001, tdo_en=0, ext_sel=0.
- From TLR, tms 0,1,0,0 (RTI→SEL_DR→CAP_DR→SHIFT_DR), then 32 shift edges with tdi=0 -> tdo bits LSB-first equal 32'h1000_0001, with tdo=1 on the first shift cycle.
- Load IR: tms 0,1,1,0,0, then shift 1111 (tms=1 on the last bit), tms 1 (UPD_IR), tms 0 (RTI) -> ir=4'b1111. During SHIFT_IR the first tdo bits are 1,0,0,0.
- BYPASS DR scan, tdi pattern 1,0,1,1 -> tdo delayed by one edge: 0,1,0,1. Leave SHIFT_DR via EXIT1 -> PAUSE_DR for 5 cycles -> EXIT2 -> SHIFT_DR; the bypass bit is preserved across the pause.
- Load OP_EXTEST -> ext_sel=1. A DR scan gives capture_dr for 1 cycle, shift_dr for N cycles and update_dr for 1 cycle, and tdo follows ext_tdo.
- Assert reset during SHIFT_IR after 2 bits -> next cycle state=0 and ir=4'b0001; the aborted IR value is never applied.
